xc_malu_pmul_seq: RTL and testbench

Sequencer for the packed shift-add multiply step datapath (`xc_malu_pmul`) in the multi-cycle ALU. It serves `pmul` and `pmulh` requests over a valid/ready handshake and owns the accumulator, argument and step-counter registers. It iterates the step logic once per cycle until the lane width is reached, then returns the low or high half of every lane product. Invalid pack widths are rejected with an error response.

---
 rtl/xc_malu_pkg.sv | 34 +++
 rtl/xc_malu_pmul_seq_if.sv | 27 ++
 rtl/xc_malu_padd.sv | 37 +++
 rtl/xc_malu_pmul.sv | 94 +++++++++
 rtl/xc_malu_pmul_seq.sv | 173 +++++++++++++++++
 tb/tb_xc_malu_pmul_seq.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/xc_malu_pkg.sv
// Shared definitions for the multi-cycle ALU packed-multiply path:
// pack-width bit indices, FSM encoding and lane-width constants.
package xc_malu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ALEN = 64;
  localparam int unsigned CNTW = 6;
  localparam int unsigned PWW  = 5;

  // Bit positions inside the one-hot pack-width vector
  localparam int unsigned PW_32 = 0;
  localparam int unsigned PW_16 = 1;
  localparam int unsigned PW_8  = 2;
  localparam int unsigned PW_4  = 3;
  localparam int unsigned PW_2  = 4;

  localparam int unsigned LANE_W_16 = 16;
  localparam int unsigned LANE_W_8  = 8;
  localparam int unsigned LANE_W_4  = 4;
  localparam int unsigned LANE_W_2  = 2;
  // Supported widths, indexed so that width g is LANE_W_16 >> g and uses pw bit g+1
  localparam int unsigned NUM_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic pw_legal(input logic [PWW-1:0] pw);
    return !pw[PW_32] && $onehot(pw[PW_2:PW_16]);
  endfunction

endpackage

// File: rtl/xc_malu_pmul_seq_if.sv
// Request/response handshake bundle between a requester and the packed-multiply sequencer.
interface xc_malu_pmul_seq_if;
  import xc_malu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_rs1;
  logic [XLEN-1:0] req_rs2;
  logic [PWW-1:0]  req_pw;
  logic            req_high;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_error;

  modport master (
    output req_valid, req_rs1, req_rs2, req_pw, req_high, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, req_pw, req_high, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error
  );

endinterface

// File: rtl/xc_malu_padd.sv
// 32-bit packed adder/subtractor: the carry chain restarts at every lane boundary
// selected by the one-hot pack width; carry_o[i] is the carry out of bit i.
module xc_malu_padd
  import xc_malu_pkg::*;
(
  input  logic [XLEN-1:0] lhs_i,
  input  logic [XLEN-1:0] rhs_i,
  input  logic            sub_i,
  input  logic [PWW-1:0]  pw_i,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] carry_o
);

  always_comb begin
    logic [XLEN-1:0] rhs_x;
    logic            c;
    logic            cut;
    result_o = '0;
    carry_o  = '0;
    rhs_x    = rhs_i ^ {XLEN{sub_i}};
    c        = sub_i;
    for (int i = 0; i < XLEN; i++) begin
      cut = ((i % 32) == 0 && pw_i[PW_32]) ||
            ((i % 16) == 0 && pw_i[PW_16]) ||
            ((i %  8) == 0 && pw_i[PW_8])  ||
            ((i %  4) == 0 && pw_i[PW_4])  ||
            ((i %  2) == 0 && pw_i[PW_2]);
      if (cut) begin
        c = sub_i;
      end
      result_o[i] = lhs_i[i] ^ rhs_x[i] ^ c;
      c           = (lhs_i[i] & rhs_x[i]) | (c & (lhs_i[i] ^ rhs_x[i]));
      carry_o[i]  = c;
    end
  end

endmodule

// File: rtl/xc_malu_pmul.sv
// One shift-add step of the packed multiplier: per lane, conditionally add the
// multiplicand into the upper half of the lane accumulator, then shift the lane right.
module xc_malu_pmul
  import xc_malu_pkg::*;
(
  input  logic [XLEN-1:0] rs1_i,
  input  logic [ALEN-1:0] acc_i,
  input  logic [XLEN-1:0] arg_i,
  input  logic [CNTW-1:0] cnt_i,
  input  logic [PWW-1:0]  pw_i,
  output logic [XLEN-1:0] padd_lhs_o,
  output logic [XLEN-1:0] padd_rhs_o,
  output logic            padd_sub_o,
  input  logic [XLEN-1:0] padd_carry_i,
  input  logic [XLEN-1:0] padd_result_i,
  output logic [ALEN-1:0] n_accumulator_o,
  output logic [XLEN-1:0] n_argument_o,
  output logic            finished_o
);

  logic [NUM_W-1:0][XLEN-1:0] lhs_w;
  logic [NUM_W-1:0][XLEN-1:0] rhs_w;
  logic [NUM_W-1:0][XLEN-1:0] narg_w;
  logic [NUM_W-1:0][ALEN-1:0] nacc_w;
  logic [CNTW-1:0]            lane_w;
  logic                       unused_pmul;

  for (genvar g = 0; g < NUM_W; g++) begin : g_width
    localparam int unsigned W = LANE_W_16 >> g;
    localparam int unsigned N = XLEN / W;

    logic [XLEN-1:0] lhs;
    logic [XLEN-1:0] rhs;
    logic [XLEN-1:0] narg;
    logic [ALEN-1:0] nacc;

    // Adder operands: upper half of each lane accumulator and the gated multiplicand
    always_comb begin
      lhs  = '0;
      rhs  = '0;
      narg = '0;
      for (int l = 0; l < N; l++) begin
        lhs[l*W +: W]  = acc_i[2*W*l+W +: W];
        rhs[l*W +: W]  = rs1_i[l*W +: W] & {W{arg_i[l*W]}};
        narg[l*W +: W] = {1'b0, arg_i[l*W+1 +: W-1]};
      end
    end

    // Lane carry becomes the new top bit; the lane's low half shifts down by one
    always_comb begin
      nacc = '0;
      for (int l = 0; l < N; l++) begin
        nacc[2*W*l +: 2*W] = {padd_carry_i[l*W+W-1], padd_result_i[l*W +: W],
                              acc_i[2*W*l+1 +: W-1]};
      end
    end

    assign lhs_w[g]  = lhs;
    assign rhs_w[g]  = rhs;
    assign narg_w[g] = narg;
    assign nacc_w[g] = nacc;
  end

  always_comb begin
    padd_lhs_o   = '0;
    padd_rhs_o   = '0;
    n_argument_o = '0;
    lane_w       = '0;
    for (int g = 0; g < NUM_W; g++) begin
      if (pw_i[g+1]) begin
        padd_lhs_o   = lhs_w[g];
        padd_rhs_o   = rhs_w[g];
        n_argument_o = narg_w[g];
        lane_w       = CNTW'(LANE_W_16 >> g);
      end
    end
  end

  always_comb begin
    n_accumulator_o = '0;
    for (int g = 0; g < NUM_W; g++) begin
      if (pw_i[g+1]) begin
        n_accumulator_o = nacc_w[g];
      end
    end
  end

  assign padd_sub_o = 1'b0;
  assign finished_o = (cnt_i == lane_w);

  // Only lane-top carries and no acc bit 0 feed the step
  assign unused_pmul = ^{acc_i[0], pw_i[PW_32], padd_carry_i};

endmodule

// File: rtl/xc_malu_pmul_seq.sv
// Sequencer for packed pmul/pmulh: accepts a request, iterates the shift-add
// step once per cycle for lane-width steps, then presents the selected lane halves.
module xc_malu_pmul_seq
  import xc_malu_pkg::*;
(
  input  logic               g_clk,
  input  logic               g_reset,
  input  logic               flush,
  output logic               busy,
  xc_malu_pmul_seq_if.slave  bus
);

  state_e          state_q, state_d;
  logic [ALEN-1:0] acc_q,   acc_d;
  logic [XLEN-1:0] arg_q,   arg_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic [XLEN-1:0] rs1_q,   rs1_d;
  logic [PWW-1:0]  pw_q,    pw_d;
  logic            high_q,  high_d;
  logic            err_q,   err_d;

  logic            accept;
  logic [XLEN-1:0] padd_lhs;
  logic [XLEN-1:0] padd_rhs;
  logic            padd_sub;
  logic [XLEN-1:0] padd_carry;
  logic [XLEN-1:0] padd_result;
  logic [ALEN-1:0] n_accumulator;
  logic [XLEN-1:0] n_argument;
  logic            finished;

  logic [NUM_W-1:0][XLEN-1:0] res_w;
  logic [XLEN-1:0]            result;

  xc_malu_pmul u_pmul (
    .rs1_i           (rs1_q),
    .acc_i           (acc_q),
    .arg_i           (arg_q),
    .cnt_i           (cnt_q),
    .pw_i            (pw_q),
    .padd_lhs_o      (padd_lhs),
    .padd_rhs_o      (padd_rhs),
    .padd_sub_o      (padd_sub),
    .padd_carry_i    (padd_carry),
    .padd_result_i   (padd_result),
    .n_accumulator_o (n_accumulator),
    .n_argument_o    (n_argument),
    .finished_o      (finished)
  );

  xc_malu_padd u_padd (
    .lhs_i    (padd_lhs),
    .rhs_i    (padd_rhs),
    .sub_i    (padd_sub),
    .pw_i     (pw_q),
    .result_o (padd_result),
    .carry_o  (padd_carry)
  );

  // Ready in DONE follows rsp_ready so a new request can ride the response handshake
  assign bus.req_ready = !flush &&
                         (state_q == ST_IDLE || (state_q == ST_DONE && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      arg_q   <= '0;
      cnt_q   <= '0;
      rs1_q   <= '0;
      pw_q    <= '0;
      high_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
      rs1_q   <= rs1_d;
      pw_q    <= pw_d;
      high_q  <= high_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    rs1_d   = rs1_q;
    pw_d    = pw_q;
    high_d  = high_q;
    err_d   = err_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!finished) begin
            acc_d = n_accumulator;
            arg_d = n_argument;
            cnt_d = cnt_q + CNTW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.rsp_ready) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
          end
        end
        default: ;
      endcase

      // An illegal width skips RUN and answers with an error straight away
      if (accept) begin
        rs1_d  = bus.req_rs1;
        pw_d   = bus.req_pw;
        high_d = bus.req_high;
        acc_d  = '0;
        arg_d  = bus.req_rs2;
        cnt_d  = '0;
        if (pw_legal(bus.req_pw)) begin
          state_d = ST_RUN;
          err_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
    end
  end

  // Lane i product sits in acc[2w*i +: 2w]; pick its low or high half
  for (genvar g = 0; g < NUM_W; g++) begin : g_res
    localparam int unsigned W = LANE_W_16 >> g;
    localparam int unsigned N = XLEN / W;

    logic [XLEN-1:0] res;

    always_comb begin
      res = '0;
      for (int l = 0; l < N; l++) begin
        res[l*W +: W] = high_q ? acc_q[2*W*l+W +: W] : acc_q[2*W*l +: W];
      end
    end

    assign res_w[g] = res;
  end

  always_comb begin
    result = '0;
    if (!err_q) begin
      for (int g = 0; g < NUM_W; g++) begin
        if (pw_q[g+1]) begin
          result = res_w[g];
        end
      end
    end
  end

  assign bus.rsp_valid  = (state_q == ST_DONE);
  assign bus.rsp_result = result;
  assign bus.rsp_error  = err_q;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Directed bench for the packed-multiply sequencer: products, latency, errors,
// backpressure, back-to-back accept, flush and mid-operation reset.
module tb_xc_malu_pmul_seq;

  logic g_clk = 1'b0;
  logic g_reset;
  logic flush;
  logic busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  xc_malu_pmul_seq_if bus ();

  xc_malu_pmul_seq dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .flush   (flush),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  // Present a request and hold it until the accepting edge has passed
  task automatic send(input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [4:0] pw, input logic high, input string tag);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_pw    = pw;
    bus.req_high  = high;
    #1;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "/accept"}, 32'(n < 50), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (!bus.rsp_valid && edges < 64) begin
      tick();
      edges++;
    end
  endtask

  task automatic do_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] pw,
                       input logic high, input logic [31:0] exp_res, input logic exp_err,
                       input int exp_edges, input string tag);
    int e;
    bus.rsp_ready = 1'b1;
    send(rs1, rs2, pw, high, tag);
    wait_rsp(e);
    check({tag, "/latency"}, 32'(e), 32'(exp_edges));
    check({tag, "/result"}, bus.rsp_result, exp_res);
    check({tag, "/error"}, 32'(bus.rsp_error), 32'(exp_err));
    tick();
    check({tag, "/idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int e;
    logic seen;

    g_reset       = 1'b1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.req_pw    = '0;
    bus.req_high  = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (2) tick();
    g_reset = 1'b0;
    #1;
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst/result", bus.rsp_result, 32'h0);
    check("rst/error", 32'(bus.rsp_error), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);

    // Products, latency w+1 edges after the accept edge
    do_op(32'h0003_FFFF, 32'h0005_FFFF, 5'b00010, 1'b0, 32'h000F_0001, 1'b0, 17, "pw16_lo");
    do_op(32'h0003_FFFF, 32'h0005_FFFF, 5'b00010, 1'b1, 32'h0000_FFFE, 1'b0, 17, "pw16_hi");
    do_op(32'h0210_FF07, 32'h0310_FF09, 5'b00100, 1'b0, 32'h0600_013F, 1'b0, 9,  "pw8_lo");
    do_op(32'h0210_FF07, 32'h0310_FF09, 5'b00100, 1'b1, 32'h0001_FE00, 1'b0, 9,  "pw8_hi");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b0, 32'h5555_5555, 1'b0, 3,  "pw2_lo");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 1'b1, 32'hAAAA_AAAA, 1'b0, 3,  "pw2_hi");
    do_op(32'h9000_00F3, 32'h9000_0025, 5'b01000, 1'b1, 32'h5000_0010, 1'b0, 5,  "pw4_hi");

    // Illegal widths answer in the cycle right after accept, then a normal op
    do_op(32'h0003_FFFF, 32'h0005_FFFF, 5'b00001, 1'b0, 32'h0, 1'b1, 0, "ill_pw32");
    do_op(32'h0003_FFFF, 32'h0005_FFFF, 5'b00110, 1'b0, 32'h0, 1'b1, 0, "ill_multi");
    do_op(32'h0003_FFFF, 32'h0005_FFFF, 5'b00010, 1'b1, 32'h0000_FFFE, 1'b0, 17, "post_err");

    // Backpressure in DONE, then response and new accept on the same edge
    bus.rsp_ready = 1'b0;
    send(32'h0210_FF07, 32'h0310_FF09, 5'b00100, 1'b0, "bp");
    wait_rsp(e);
    check("bp/latency", 32'(e), 32'd9);
    bus.req_valid = 1'b1;
    bus.req_rs1   = 32'h9000_00F3;
    bus.req_rs2   = 32'h9000_0025;
    bus.req_pw    = 5'b01000;
    bus.req_high  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp/hold_result", bus.rsp_result, 32'h0600_013F);
      check("bp/req_ready", 32'(bus.req_ready), 32'd0);
    end
    check("bp/rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    #1;
    check("b2b/req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    check("b2b/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("b2b/busy", 32'(busy), 32'd1);
    wait_rsp(e);
    check("b2b/latency", 32'(e), 32'd5);
    check("b2b/result", bus.rsp_result, 32'h1000_00EF);
    tick();

    // Flush with cnt=3
    send(32'h0003_FFFF, 32'h0005_FFFF, 5'b00010, 1'b0, "flush");
    repeat (3) tick();
    flush = 1'b1;
    #1;
    check("flush/req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    check("flush/busy", 32'(busy), 32'd0);
    check("flush/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("flush/no_rsp", 32'(seen), 32'd0);

    // Reset with cnt=3
    send(32'h0003_FFFF, 32'h0005_FFFF, 5'b00010, 1'b0, "mid_rst");
    repeat (3) tick();
    g_reset = 1'b1;
    tick();
    g_reset = 1'b0;
    #1;
    check("mid_rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("mid_rst/rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst/result", bus.rsp_result, 32'h0);
    check("mid_rst/error", 32'(bus.rsp_error), 32'd0);
    check("mid_rst/busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("mid_rst/no_rsp", 32'(seen), 32'd0);

    // Flush beats a simultaneous request
    bus.req_valid = 1'b1;
    bus.req_rs1   = 32'h0210_FF07;
    bus.req_rs2   = 32'h0310_FF09;
    bus.req_pw    = 5'b00100;
    flush         = 1'b1;
    #1;
    check("flush_req/req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_req/busy", 32'(busy), 32'd0);
    tick();
    check("flush_req/rsp_valid", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
